// File: rtl/emif_calbus_pkg.sv
// Shared widths, table geometry and the host response pipeline entry for emif_calbus_mux.
// EMIF_CALBUS_PARAM_TBL_EN adds the parameter-table fields to the entry.
package emif_calbus_pkg;

    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 32;
    localparam int TBL_BITS  = 4096;
    localparam int TBL_WORDS = 128;
    localparam int TBL_IDX_W = 7;

    localparam logic [7:0] TBL_BASE_DEF = 8'hFF;

    typedef struct packed {
        logic              valid;
`ifdef EMIF_CALBUS_PARAM_TBL_EN
        logic              is_tbl;
`endif
        logic              is_write;
`ifdef EMIF_CALBUS_PARAM_TBL_EN
        logic [DATA_W-1:0] tbl_word;
`endif
    } rsp_entry_t;

    localparam int RSP_W = $bits(rsp_entry_t);

    function automatic logic [DATA_W-1:0] tbl_word_at(input logic [TBL_BITS-1:0] tbl,
                                                      input logic [TBL_IDX_W-1:0] idx);
        return tbl[{idx, 5'b0} +: DATA_W];
    endfunction

endpackage

// File: rtl/emif_calbus_rsp_pipe.sv
// Fixed-depth shift register carrying one host response entry per stage.
// Every cycle shifts; an idle cycle pushes an invalid entry.
module emif_calbus_rsp_pipe
    import emif_calbus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [RSP_W-1:0] push_i,
    output logic [RSP_W-1:0] tail_o
);

    rsp_entry_t stage_q [DEPTH];
    rsp_entry_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = rsp_entry_t'(push_i);
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/emif_calbus_mux.sv
// Calibration-bus mux: cal master passes through, debug host is granted in idle gaps.
// EMIF_CALBUS_PARAM_TBL_EN enables the host window onto the sequencer parameter table.
module emif_calbus_mux
    import emif_calbus_pkg::*;
#(
    parameter int         RD_LATENCY = 2,
    parameter int         HOST_GAP   = 4,
    parameter logic [7:0] TBL_BASE   = TBL_BASE_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cal_read_i,
    input  logic          cal_write_i,
    input  logic [19:0]   cal_address_i,
    input  logic [31:0]   cal_wdata_i,
    output logic [31:0]   cal_rdata_o,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [19:0]   host_addr_i,
    input  logic [31:0]   host_wdata_i,
    output logic          host_gnt_o,
    output logic          host_rvalid_o,
    output logic [31:0]   host_rdata_o,
    output logic          emif_read_o,
    output logic          emif_write_o,
    output logic [19:0]   emif_address_o,
    output logic [31:0]   emif_wdata_o,
    input  logic [31:0]   emif_rdata_i,
    input  logic [4095:0] seq_param_tbl_i,
    output logic          cal_busy_o
);

    localparam logic [3:0] GAP_MAX = HOST_GAP[3:0];

    logic              cal_act;
    logic              host_gnt;
    logic              host_is_tbl;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    rsp_entry_t        rsp_push;
    rsp_entry_t        rsp_tail;
    logic [RSP_W-1:0]  rsp_tail_bits;

    assign cal_act     = cal_read_i | cal_write_i;
    assign cal_rdata_o = emif_rdata_i;

`ifdef EMIF_CALBUS_PARAM_TBL_EN
    assign host_is_tbl = (host_addr_i[19:12] == TBL_BASE);
`else
    logic unused_tbl;
    assign host_is_tbl = 1'b0;
    assign unused_tbl  = ^{seq_param_tbl_i, TBL_BASE};
`endif

    // gap_cnt is 0 during reset, so the grant is held low there as well.
    assign host_gnt   = host_req_i & ~cal_act & (gap_cnt_q == GAP_MAX);
    assign host_gnt_o = host_gnt;
    assign cal_busy_o = (gap_cnt_q < GAP_MAX);

    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (cal_act) begin
            gap_cnt_d = '0;
        end else if (gap_cnt_q != GAP_MAX) begin
            gap_cnt_d = gap_cnt_q + 4'd1;
        end
    end

    always_comb begin
        emif_read_o    = 1'b0;
        emif_write_o   = 1'b0;
        emif_address_o = cal_address_i;
        emif_wdata_o   = cal_wdata_i;
        if (cal_act) begin
            emif_read_o  = cal_read_i;
            emif_write_o = cal_write_i;
        end else if (host_gnt && !host_is_tbl) begin
            emif_read_o    = ~host_we_i;
            emif_write_o   = host_we_i;
            emif_address_o = host_addr_i;
            emif_wdata_o   = host_wdata_i;
        end
    end

    always_comb begin
        rsp_push          = '0;
        rsp_push.valid    = host_gnt;
        rsp_push.is_write = host_we_i;
`ifdef EMIF_CALBUS_PARAM_TBL_EN
        rsp_push.is_tbl   = host_is_tbl;
        rsp_push.tbl_word = tbl_word_at(seq_param_tbl_i, host_addr_i[TBL_IDX_W-1:0]);
`endif
    end

    emif_calbus_rsp_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rsp_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (rsp_push),
        .tail_o (rsp_tail_bits)
    );

    assign rsp_tail = rsp_entry_t'(rsp_tail_bits);

    // The tail entry lines up with the cycle the target presents read data.
    always_comb begin
        rvalid_d = rsp_tail.valid;
        rdata_d  = '0;
        if (rsp_tail.valid && !rsp_tail.is_write) begin
            rdata_d = emif_rdata_i;
`ifdef EMIF_CALBUS_PARAM_TBL_EN
            if (rsp_tail.is_tbl) begin
                rdata_d = rsp_tail.tbl_word;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gap_cnt_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign host_rvalid_o = rvalid_q;
    assign host_rdata_o  = rdata_q;

endmodule

// File: tb/tb_emif_calbus_mux.sv
// Directed bench for emif_calbus_mux (RD_LATENCY=2, HOST_GAP=4).
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
module tb_emif_calbus_mux;

    logic          clk = 1'b0;
    logic          rst;
    logic          cal_read, cal_write;
    logic [19:0]   cal_address;
    logic [31:0]   cal_wdata, cal_rdata;
    logic          host_req, host_we;
    logic [19:0]   host_addr;
    logic [31:0]   host_wdata;
    logic          host_gnt, host_rvalid;
    logic [31:0]   host_rdata;
    logic          emif_read, emif_write;
    logic [19:0]   emif_address;
    logic [31:0]   emif_wdata, emif_rdata;
    logic [4095:0] tbl;
    logic          cal_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    emif_calbus_mux #(
        .RD_LATENCY (2),
        .HOST_GAP   (4),
        .TBL_BASE   (8'hFF)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cal_read_i      (cal_read),
        .cal_write_i     (cal_write),
        .cal_address_i   (cal_address),
        .cal_wdata_i     (cal_wdata),
        .cal_rdata_o     (cal_rdata),
        .host_req_i      (host_req),
        .host_we_i       (host_we),
        .host_addr_i     (host_addr),
        .host_wdata_i    (host_wdata),
        .host_gnt_o      (host_gnt),
        .host_rvalid_o   (host_rvalid),
        .host_rdata_o    (host_rdata),
        .emif_read_o     (emif_read),
        .emif_write_o    (emif_write),
        .emif_address_o  (emif_address),
        .emif_wdata_o    (emif_wdata),
        .emif_rdata_i    (emif_rdata),
        .seq_param_tbl_i (tbl),
        .cal_busy_o      (cal_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 20'h00100;
        idle(2);
        @(negedge clk);
        total++;
        if (host_rvalid !== 1'b0 || host_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_rsp: rvalid=%b rdata=%h want 0/0", host_rvalid, host_rdata);
        end
        total++;
        if (cal_busy !== 1'b1 || host_gnt !== 1'b0) begin
            bad++; $display("FAIL reset_ctl: busy=%b gnt=%b want 1/0", cal_busy, host_gnt);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            total++;
            if (host_gnt !== (c == 4) || cal_busy !== (c < 4)) begin
                bad++; $display("FAIL first_grant c=%0d: gnt=%b busy=%b want %b/%b",
                                c, host_gnt, cal_busy, c == 4, c < 4);
            end
            if (c == 4) begin
                total++;
                if (emif_read !== 1'b1 || emif_write !== 1'b0 || emif_address !== 20'h00100) begin
                    bad++; $display("FAIL first_grant_bus: rd=%b wr=%b addr=%h want 1/0/00100",
                                    emif_read, emif_write, emif_address);
                end
            end
            step();
        end
        host_req = 1'b0;
        idle(5);
    endtask

    task automatic test_read();
        host_req = 1'b1; host_we = 1'b0; host_addr = 20'h00100; emif_rdata = 32'h0BADF00D;
        @(negedge clk);
        total++;
        if (host_gnt !== 1'b1 || emif_read !== 1'b1 || emif_address !== 20'h00100) begin
            bad++; $display("FAIL read_issue: gnt=%b rd=%b addr=%h want 1/1/00100",
                            host_gnt, emif_read, emif_address);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            host_req = 1'b0;
            emif_rdata = (k == 2) ? 32'hDEADBEEF : 32'h0BADF00D;
            @(negedge clk);
            total++;
            if (host_rvalid !== (k == 3) || (k == 3 && host_rdata !== 32'hDEADBEEF)) begin
                bad++; $display("FAIL read_rsp k=%0d: rvalid=%b rdata=%h want %b/deadbeef",
                                k, host_rvalid, host_rdata, k == 3);
            end
        end
        total++;
        if (cal_rdata !== 32'h0BADF00D) begin
            bad++; $display("FAIL cal_rdata: got %h want 0badf00d", cal_rdata);
        end
        step();
    endtask

    task automatic test_cal_collision();
        cal_read = 1'b1; cal_address = 20'h0ABCD; cal_wdata = 32'h01020304;
        host_req = 1'b1; host_we = 1'b0; host_addr = 20'h00200;
        @(negedge clk);
        total++;
        if (host_gnt !== 1'b0 || emif_read !== 1'b1 || emif_address !== 20'h0ABCD
            || emif_wdata !== 32'h01020304) begin
            bad++; $display("FAIL cal_wins: gnt=%b rd=%b addr=%h wd=%h want 0/1/0abcd/01020304",
                            host_gnt, emif_read, emif_address, emif_wdata);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            cal_read = 1'b0;
            @(negedge clk);
            total++;
            if (host_gnt !== (k == 5) || cal_busy !== (k < 5)) begin
                bad++; $display("FAIL regrant k=%0d: gnt=%b busy=%b want %b/%b",
                                k, host_gnt, cal_busy, k == 5, k < 5);
            end
        end
        step();
        host_req = 1'b0;
        idle(4);
    endtask

    task automatic test_back_to_back();
        host_req = 1'b1; host_we = 1'b1; host_addr = 20'h00300; host_wdata = 32'h11112222;
        emif_rdata = 32'h5555AAAA;
        @(negedge clk);
        total++;
        if (host_gnt !== 1'b1 || emif_write !== 1'b1 || emif_read !== 1'b0
            || emif_wdata !== 32'h11112222 || emif_address !== 20'h00300) begin
            bad++; $display("FAIL b2b_write: gnt=%b wr=%b rd=%b wd=%h addr=%h",
                            host_gnt, emif_write, emif_read, emif_wdata, emif_address);
        end
        step();
        host_we = 1'b0; host_addr = 20'h00304;
        @(negedge clk);
        total++;
        if (host_gnt !== 1'b1 || emif_read !== 1'b1 || emif_address !== 20'h00304) begin
            bad++; $display("FAIL b2b_read: gnt=%b rd=%b addr=%h want 1/1/00304",
                            host_gnt, emif_read, emif_address);
        end
        for (int k = 2; k <= 6; k++) begin
            step();
            host_req = 1'b0;
            emif_rdata = (k == 3) ? 32'hCAFEF00D : 32'h5555AAAA;
            @(negedge clk);
            total++;
            if (host_rvalid !== (k == 3 || k == 4)
                || (k == 3 && host_rdata !== 32'h0)
                || (k == 4 && host_rdata !== 32'hCAFEF00D)) begin
                bad++; $display("FAIL b2b_rsp k=%0d: rvalid=%b rdata=%h", k, host_rvalid, host_rdata);
            end
        end
        step();
    endtask

`ifdef EMIF_CALBUS_PARAM_TBL_EN
    task automatic test_table();
        host_req = 1'b1; host_we = 1'b0; host_addr = 20'hFF005; emif_rdata = 32'h0BADF00D;
        @(negedge clk);
        total++;
        if (host_gnt !== 1'b1 || emif_read !== 1'b0 || emif_write !== 1'b0) begin
            bad++; $display("FAIL tbl_issue: gnt=%b rd=%b wr=%b want 1/0/0", host_gnt, emif_read, emif_write);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            host_req = 1'b0;
            @(negedge clk);
            total++;
            if (host_rvalid !== (k == 3) || (k == 3 && host_rdata !== 32'h12345678)) begin
                bad++; $display("FAIL tbl_rsp k=%0d: rvalid=%b rdata=%h want %b/12345678",
                                k, host_rvalid, host_rdata, k == 3);
            end
        end
        step();
    endtask
`endif

    task automatic test_reset_mid();
        host_req = 1'b1; host_we = 1'b0; host_addr = 20'h00400; emif_rdata = 32'h77778888;
        @(negedge clk);
        total++;
        if (host_gnt !== 1'b1) begin
            bad++; $display("FAIL rst_mid_gnt: gnt=%b want 1", host_gnt);
        end
        step();
        host_req = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (host_rvalid !== 1'b0 || host_rdata !== 32'h0 || cal_busy !== 1'b1) begin
            bad++; $display("FAIL rst_mid_now: rvalid=%b rdata=%h busy=%b want 0/0/1",
                            host_rvalid, host_rdata, cal_busy);
        end
        idle(2);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (host_rvalid !== 1'b0) begin
                bad++; $display("FAIL rst_mid_rsp k=%0d: rvalid=%b want 0", k, host_rvalid);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        cal_read = 1'b0; cal_write = 1'b0; cal_address = 20'h0; cal_wdata = 32'h0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 20'h0; host_wdata = 32'h0;
        emif_rdata = 32'h0;
        tbl = '0;
        for (int w = 0; w < 128; w++) tbl[w*32 +: 32] = 32'hA5000000 | w;
        tbl[5*32 +: 32] = 32'h12345678;
        #1;
        test_reset();
        test_read();
        test_cal_collision();
        test_back_to_back();
`ifdef EMIF_CALBUS_PARAM_TBL_EN
        test_table();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/emif_calbus_mux.md
# emif_calbus_mux

Calibration-bus multiplexer between the `emif_cal` sequencer master and the EMIF calbus target. It runs in the `calbus_clk` domain. Calibration traffic passes through with zero added latency. A debug host port (req/gnt/rvalid) can issue reads and writes into calbus address space only in gaps of calibration traffic. Host responses return through a fixed-latency tag pipeline. An optional window serves words of the 4096-bit sequencer parameter table directly to the host.

## Interface
Parameters:
- `RD_LATENCY`, 2: cycles from calbus read strobe to valid `emif_rdata_i`; range 1–8.
- `HOST_GAP`, 4: consecutive idle calibration cycles required before a host grant; range 1–15.
- `TBL_BASE`, 8'hFF: value of `addr[19:12]` that selects the parameter-table window.

Ports:
- `clk_i` in 1: clock; this is `calbus_clk`.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cal_read_i` / `cal_write_i` in 1: calibration master strobes.
- `cal_address_i` in 20: calibration master address.
- `cal_wdata_i` in 32: calibration master write data.
- `cal_rdata_o` out 32: read data back to the calibration master.
- `host_req_i`, `host_we_i` in 1: host request and write select.
- `host_addr_i` in 20, `host_wdata_i` in 32: host address and write data.
- `host_gnt_o` out 1: host grant.
- `host_rvalid_o` out 1: host response valid.
- `host_rdata_o` out 32: host response data.
- `emif_read_o`, `emif_write_o` out 1: strobes to the calbus target.
- `emif_address_o` out 20, `emif_wdata_o` out 32: address and write data to the calbus target.
- `emif_rdata_i` in 32: read data from the calbus target.
- `seq_param_tbl_i` in 4096: sequencer parameter table.
- `cal_busy_o` out 1: high while the idle counter is below `HOST_GAP`.

## Operation
- `cal_act = cal_read_i | cal_write_i`. While `cal_act` is high, all `emif_*` outputs equal the `cal_*` inputs combinationally. A cycle with both calibration strobes high is forwarded unchanged and is not checked.
- `cal_rdata_o = emif_rdata_i` always, combinationally. The calibration master owns its own latency.
- Idle counter `gap_cnt` (4 bits):
  - Clears on `cal_act`.
  - Otherwise increments, saturating at `HOST_GAP`.
  - Reset value is 0.
- Grant: `host_gnt_o = host_req_i & ~cal_act & (gap_cnt == HOST_GAP)`. The grant is combinational. The host holds its request stable until granted.
- Granted access to a non-window address:
  - Drives `emif_read_o = ~host_we_i` or `emif_write_o = host_we_i`.
  - Drives `emif_address_o = host_addr_i` and `emif_wdata_o = host_wdata_i`.
- Granted access to the window address, with the feature enabled: no calbus strobe is issued.
- When no access is issued, `emif_*` strobes are 0, and address/wdata follow the `cal_*` inputs.
- Response pipeline: a shift register of depth `RD_LATENCY` holds one entry per stage, `{valid, is_tbl, is_write, tbl_word}`. Every grant pushes an entry; writes are acknowledged too.
- Response data:
  - Host read: `emif_rdata_i` sampled at stage `RD_LATENCY`.
  - Table read: `tbl_word`, captured at grant as `seq_param_tbl_i[idx*32 +: 32]`, with `idx = host_addr_i[6:0]`.
  - Write: data 0.
- Responses are strictly in order. One grant per cycle is allowed, and there is no outstanding limit.
- Window writes are dropped and still acknowledged.

## Timing
- Host grant in cycle N:
  - Calbus strobe in cycle N.
  - `emif_rdata_i` sampled at the N+`RD_LATENCY` edge.
  - `host_rvalid_o`/`host_rdata_o` valid in cycle N+`RD_LATENCY`+1 for exactly one cycle; both are registered.
- Calibration strobe and host request in the same cycle: the calibration access wins, no grant is given, and `gap_cnt` clears.
- A calibration strobe arriving while host responses are in flight is legal. Fixed latency prevents any collision; in-flight entries complete normally.
- Reset values: `host_rvalid_o` 0, `host_rdata_o` 0, `gap_cnt` 0 (so `cal_busy_o` = 1), pipeline all invalid. During reset `host_gnt_o` is 0.
- Reset asserted mid-operation: all in-flight host responses are discarded; no rvalid is produced for them.

## Configuration
- `EMIF_CALBUS_PARAM_TBL_EN` defined:
  - `host_addr_i[19:12] == TBL_BASE` selects the table window, as described above.
  - Undefined: there is no window; all host accesses go to calbus.
  - Undefined: `seq_param_tbl_i` is unused and the `is_tbl`/`tbl_word` pipeline fields are removed.

## Structure
- Package `emif_calbus_pkg`:
  - Address/data width constants (20, 32).
  - Table size constants (4096 bits, 128 words).
  - The pipeline entry struct type.
  - `TBL_BASE` default.
- One sub-module, `emif_calbus_rsp_pipe`: parameterised-depth response shift register with synchronous push and asynchronous reset.

## Test plan
- Reset release with a host request pending: the first grant comes no earlier than cycle `HOST_GAP` after reset release, assuming no calibration traffic.
- Host read at address 0x00100, `RD_LATENCY` = 2, target returns 0xDEADBEEF: exactly one `host_rvalid_o`, 3 cycles after the grant, with data 0xDEADBEEF.
- Calibration read strobe in the same cycle as a host request: the calibration address reaches `emif_address_o`, there is no grant, and the next grant is exactly `HOST_GAP` idle cycles later.
- Back-to-back host write then read on consecutive cycles: two in-order rvalids, the first with data 0.
- With the macro defined, host read at 0xFF005 with table word 5 = 0x12345678: no calbus strobe, and rvalid carries 0x12345678 after `RD_LATENCY`+1 cycles.
- Reset asserted one cycle after a host read grant: no rvalid is ever produced, and all outputs go to their reset values immediately.
